// File: rtl/lsu_mem_stage.sv
// Load/store unit: takes one memory op from execute, runs a req/gnt/rvalid bus
// transaction, aligns and extends load data, and drives the register-file write port.
module lsu_mem_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_load,
  input  logic            in_store,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_addr,
  input  logic [XLEN-1:0] in_wdata,
  input  logic [4:0]      in_rd,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_wstrb,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            wb_en,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            exc,
  output logic [XLEN-1:0] exc_addr,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t          state;
  logic [2:0]      funct3_q;
  logic [1:0]      off_q;
  logic [4:0]      rd_q;
  logic            load_q;

  logic            accept;
  logic            bad;
  logic [XLEN-1:0] st_data;
  logic [3:0]      st_strb;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] ld_data;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  // An op with neither flag set is not accepted at all.
  assign accept   = in_valid && in_ready && (in_load || in_store);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    bad     = 1'b0;
    st_data = in_wdata;
    st_strb = 4'b1111;
    if (in_load && in_store) begin
      bad = 1'b1;
    end else if (in_store) begin
      case (in_funct3)
        3'b000:  bad = 1'b0;
        3'b001:  bad = in_addr[0];
        3'b010:  bad = |in_addr[1:0];
        default: bad = 1'b1;
      endcase
    end else begin
      case (in_funct3)
        3'b000, 3'b100: bad = 1'b0;
        3'b001, 3'b101: bad = in_addr[0];
        3'b010:         bad = |in_addr[1:0];
        default:        bad = 1'b1;
      endcase
    end
    case (in_funct3[1:0])
      2'b00: begin
        st_data = {4{in_wdata[7:0]}};
        st_strb = 4'b0001 << in_addr[1:0];
      end
      2'b01: begin
        st_data = {2{in_wdata[15:0]}};
        st_strb = 4'b0011 << in_addr[1:0];
      end
      default: begin
        st_data = in_wdata;
        st_strb = 4'b1111;
      end
    endcase
  end

  // Bring the addressed byte/halfword down to lane 0, then extend.
  always_comb begin
    shifted = mem_rdata >> {off_q, 3'b000};
    case (funct3_q)
      3'b000:  ld_data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      3'b001:  ld_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      3'b100:  ld_data = {{(XLEN-8){1'b0}}, shifted[7:0]};
      3'b101:  ld_data = {{(XLEN-16){1'b0}}, shifted[15:0]};
      default: ld_data = mem_rdata;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      funct3_q  <= '0;
      off_q     <= '0;
      rd_q      <= '0;
      load_q    <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      wb_en     <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
      exc       <= 1'b0;
      exc_addr  <= '0;
    end else begin
      wb_en <= 1'b0;
      exc   <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            funct3_q <= in_funct3;
            off_q    <= in_addr[1:0];
            rd_q     <= in_rd;
            load_q   <= in_load;
            if (bad) begin
              exc      <= 1'b1;
              exc_addr <= in_addr;
            end else begin
              state     <= REQ;
              mem_req   <= 1'b1;
              mem_we    <= in_store;
              mem_addr  <= {in_addr[XLEN-1:2], 2'b00};
              mem_wdata <= in_store ? st_data : '0;
              mem_wstrb <= in_store ? st_strb : 4'b0000;
            end
          end
        end
        // rvalid is deliberately ignored here, including a same-cycle gnt+rvalid.
        REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            state   <= load_q ? WAIT : IDLE;
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            wb_data <= ld_data;
            wb_rd   <= rd_q;
            wb_en   <= (rd_q != 5'd0);
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
